// File: rtl/x_top_uart_cmd.sv
// UART byte-stream command decoder: assembles W/R frames into 32-bit bus requests.
// Define X_TOP_UART_CMD_CHK_EN to require a trailing XOR checksum byte per frame.
module x_top_uart_cmd #(
  parameter int unsigned p_timeout_cycles = 10000,
  parameter logic [7:0]  p_cmd_wr         = 8'h57,
  parameter logic [7:0]  p_cmd_rd         = 8'h52
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic        o_req_we,
  output logic [31:0] o_req_addr,
  output logic [31:0] o_req_wdata,
  output logic        o_err,
  output logic        o_busy
);

  localparam int unsigned TW = (p_timeout_cycles > 2) ? $clog2(p_timeout_cycles) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(p_timeout_cycles - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
`ifdef X_TOP_UART_CMD_CHK_EN
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_DONE = S_CHK;
`else
  localparam logic [2:0] S_DONE = S_REQ;
`endif

  logic [2:0]    state;
  logic [1:0]    count;
  logic [TW-1:0] tmo;
  logic          collecting;
  logic          tmo_hit;
`ifdef X_TOP_UART_CMD_CHK_EN
  logic [7:0]    chk;
`endif

  always_comb begin
    collecting = (state == S_ADDR) || (state == S_DATA);
`ifdef X_TOP_UART_CMD_CHK_EN
    collecting = collecting || (state == S_CHK);
`endif
    tmo_hit = collecting && !i_valid && (tmo == TMO_LAST);
  end

  assign o_req_valid = (state == S_REQ);
  assign o_busy      = (state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      count       <= '0;
      tmo         <= '0;
      o_req_we    <= 1'b0;
      o_req_addr  <= '0;
      o_req_wdata <= '0;
      o_err       <= 1'b0;
`ifdef X_TOP_UART_CMD_CHK_EN
      chk         <= '0;
`endif
    end else begin
      o_err <= 1'b0;
      if (collecting) tmo <= i_valid ? '0 : tmo + TW'(1);
      case (state)
        S_IDLE: if (i_valid) begin
          if (i_data == p_cmd_wr || i_data == p_cmd_rd) begin
            o_req_we    <= (i_data == p_cmd_wr);
            o_req_addr  <= '0;
            o_req_wdata <= '0;
            count       <= '0;
            tmo         <= '0;
            state       <= S_ADDR;
`ifdef X_TOP_UART_CMD_CHK_EN
            chk         <= i_data;
`endif
          end else begin
            o_err <= 1'b1;
          end
        end
        S_ADDR: if (i_valid) begin
          o_req_addr[{count, 3'b000} +: 8] <= i_data;
          count <= count + 2'd1;
`ifdef X_TOP_UART_CMD_CHK_EN
          chk   <= chk ^ i_data;
`endif
          if (count == 2'd3) state <= o_req_we ? S_DATA : S_DONE;
        end
        S_DATA: if (i_valid) begin
          o_req_wdata[{count, 3'b000} +: 8] <= i_data;
          count <= count + 2'd1;
`ifdef X_TOP_UART_CMD_CHK_EN
          chk   <= chk ^ i_data;
`endif
          if (count == 2'd3) state <= S_DONE;
        end
`ifdef X_TOP_UART_CMD_CHK_EN
        S_CHK: if (i_valid) begin
          if (i_data == chk) begin
            state <= S_REQ;
          end else begin
            state <= S_IDLE;
            o_err <= 1'b1;
          end
        end
`endif
        S_REQ: begin
          // A byte arriving while the request is pending is dropped, never queued.
          if (i_valid) o_err <= 1'b1;
          if (i_req_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (tmo_hit) begin
        state <= S_IDLE;
        tmo   <= '0;
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_x_top_uart_cmd.sv
// Self-checking bench for x_top_uart_cmd: frame-level reference model plus directed
// literal checks and randomized byte streams with random backpressure.
module tb_x_top_uart_cmd;

  localparam int unsigned P = 16;
`ifdef X_TOP_UART_CMD_CHK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_req_ready = 1'b1;
  logic        o_req_valid, o_req_we, o_err, o_busy;
  logic [31:0] o_req_addr, o_req_wdata;

  x_top_uart_cmd #(
    .p_timeout_cycles(P),
    .p_cmd_wr(8'h57),
    .p_cmd_rd(8'h52)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .i_data(i_data),
    .o_req_valid(o_req_valid),
    .i_req_ready(i_req_ready),
    .o_req_we(o_req_we),
    .o_req_addr(o_req_addr),
    .o_req_wdata(o_req_wdata),
    .o_err(o_err),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  bit rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: bytes of the frame in progress, idle cycles since the last byte,
  // and the request waiting for the bus master.
  logic [7:0]  frame[$];
  int          idle_cnt;
  bit          m_pend, m_we, m_err, m_e, m_ok;
  logic [31:0] m_addr, m_wdata;
  logic [7:0]  m_x;

  function automatic int frame_len(input logic [7:0] cmd);
    return ((cmd == 8'h57) ? 9 : 5) + EXTRA;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame.delete();
      idle_cnt = 0;
      m_pend = 1'b0;
      m_err = 1'b0;
    end else begin
      m_e = 1'b0;
      if (m_pend) begin
        if (i_valid) m_e = 1'b1;
        if (i_req_ready) m_pend = 1'b0;
      end else if (frame.size() == 0) begin
        if (i_valid) begin
          if (i_data == 8'h57 || i_data == 8'h52) begin
            frame.push_back(i_data);
            idle_cnt = 0;
          end else begin
            m_e = 1'b1;
          end
        end
      end else if (i_valid) begin
        frame.push_back(i_data);
        idle_cnt = 0;
        if (frame.size() == frame_len(frame[0])) begin
          m_x = 8'h00;
          for (int k = 0; k < frame.size() - EXTRA; k++) m_x ^= frame[k];
          m_ok = (EXTRA == 0) || (m_x == frame[frame.size() - 1]);
          if (m_ok) begin
            m_pend  = 1'b1;
            m_we    = (frame[0] == 8'h57);
            m_addr  = {frame[4], frame[3], frame[2], frame[1]};
            m_wdata = m_we ? {frame[8], frame[7], frame[6], frame[5]} : 32'h0;
          end else begin
            m_e = 1'b1;
          end
          frame.delete();
        end
      end else begin
        idle_cnt++;
        if (idle_cnt == P) begin
          m_e = 1'b1;
          frame.delete();
        end
      end
      m_err = m_e;
    end
  end

  always @(negedge i_clk) begin
    check("req_valid", o_req_valid, m_pend);
    check("err", o_err, m_err);
    check("busy", o_busy, m_pend || (frame.size() > 0));
    if (m_pend) begin
      check("req_we", o_req_we, m_we);
      check("req_addr", o_req_addr, m_addr);
      check("req_wdata", o_req_wdata, m_wdata);
    end
  end

  always @(negedge i_clk) begin
    if (rnd_ready) begin
      #1;
      i_req_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    #1;
    i_valid = 1'b1;
    i_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      #1;
      i_valid = 1'b0;
    end
  endtask

  // stall_len idle cycles are inserted after byte index stall_pos (negative: none).
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                            input int stall_pos, input int stall_len);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(cmd);
    for (int k = 0; k < 4; k++) b.push_back(a[8*k +: 8]);
    if (cmd == 8'h57) for (int k = 0; k < 4; k++) b.push_back(d[8*k +: 8]);
    x = 8'h00;
    foreach (b[k]) x ^= b[k];
    if (EXTRA != 0) b.push_back(x);
    foreach (b[k]) begin
      send_byte(b[k]);
      if (k == stall_pos) idle(stall_len);
    end
    idle(1);
  endtask

  task automatic expect_req(input string name, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
    int n;
    n = 0;
    while (!o_req_valid && n < 8) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check({name, "_seen"}, o_req_valid, 1'b1);
    check({name, "_we"}, o_req_we, we);
    check({name, "_addr"}, o_req_addr, a);
    check({name, "_wdata"}, o_req_wdata, d);
  endtask

  initial begin
    int n;
    int errs;
    int kind;
    logic [31:0] ra, rd;
    #1 i_rst = 1'b1;
    idle(3);
    i_rst = 1'b0;
    check("rst_valid", o_req_valid, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_we", o_req_we, 1'b0);
    check("rst_addr", o_req_addr, 32'h0);
    check("rst_wdata", o_req_wdata, 32'h0);

    send_frame(8'h57, 32'h40000010, 32'hDEADBEEF, -1, 0);
    expect_req("wr1", 1'b1, 32'h40000010, 32'hDEADBEEF);
    idle(2);
    send_frame(8'h52, 32'h20000004, 32'h0, -1, 0);
    expect_req("rd1", 1'b0, 32'h20000004, 32'h0);
    idle(2);
    send_frame(8'h57, 32'h12345678, 32'hCAFEF00D, -1, 0);
    expect_req("wr2", 1'b1, 32'h12345678, 32'hCAFEF00D);
    idle(2);

    send_byte(8'h41);
    idle(1);
    check("bad_err", o_err, 1'b1);
    check("bad_busy", o_busy, 1'b0);
    idle(1);
    check("bad_err_clear", o_err, 1'b0);
    send_frame(8'h52, 32'h00000100, 32'h0, -1, 0);
    expect_req("rd2", 1'b0, 32'h00000100, 32'h0);
    idle(2);

    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    idle(1);
    n = 0;
    while (!o_err && n < P + 4) begin
      idle(1);
      n++;
    end
    check("tmo_err", o_err, 1'b1);
    check("tmo_busy", o_busy, 1'b0);
    idle(2);
    send_frame(8'h57, 32'h40000010, 32'hDEADBEEF, -1, 0);
    expect_req("wr_after_tmo", 1'b1, 32'h40000010, 32'hDEADBEEF);
    idle(2);

    send_frame(8'h57, 32'h0BADF00D, 32'h87654321, 2, P - 1);
    expect_req("wr_edge_stall", 1'b1, 32'h0BADF00D, 32'h87654321);
    idle(2);

    i_req_ready = 1'b0;
    send_frame(8'h52, 32'h20000004, 32'h0, -1, 0);
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      check("bp_valid", o_req_valid, 1'b1);
      check("bp_addr", o_req_addr, 32'h20000004);
      check("bp_wdata", o_req_wdata, 32'h0);
      if (o_err) errs++;
      @(negedge i_clk);
      #1;
      i_valid = (i == 10);
      i_data  = 8'hA5;
    end
    check("bp_err_count", errs, 1);
    i_req_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_req_valid) n++;
      idle(1);
    end
    check("bp_transfers", n, 1);

    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    @(negedge i_clk);
    #1;
    i_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", o_req_valid, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_addr", o_req_addr, 32'h0);
    check("mid_rst_we", o_req_we, 1'b0);
    idle(2);
    i_rst = 1'b0;
    send_frame(8'h52, 32'h00ABCDEF, 32'h0, -1, 0);
    expect_req("rd_after_rst", 1'b0, 32'h00ABCDEF, 32'h0);
    idle(2);

    rnd_ready = 1'b1;
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 9);
      ra = $urandom;
      rd = $urandom;
      if (kind <= 3)      send_frame(8'h57, ra, rd, -1, 0);
      else if (kind <= 6) send_frame(8'h52, ra, rd, -1, 0);
      else if (kind == 7) begin send_byte(8'($urandom)); idle(1); end
      else if (kind == 8) send_frame(8'h57, ra, rd, $urandom_range(0, 7), P - 2 + $urandom_range(0, 3));
      else begin
        repeat ($urandom_range(1, 4)) send_byte(8'($urandom));
        idle(1);
      end
      idle($urandom_range(0, 4));
    end
    rnd_ready = 1'b0;
    #2;
    i_req_ready = 1'b1;
    idle(P + 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

endmodule
